// File: rtl/ps2_key_if.sv
// ps2_key_if: PS/2 pin inputs and decoded key/direction outputs of the keyboard decoder
interface ps2_key_if;
  logic       PS2Clk;
  logic       PS2Data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       dir_valid;
  logic [1:0] dir;
  logic       frame_err;
  modport master (
    input  PS2Clk, PS2Data,
    output key_valid, key_code, key_ext, key_break, dir_valid, dir, frame_err
  );
  modport slave (
    output PS2Clk, PS2Data,
    input  key_valid, key_code, key_ext, key_break, dir_valid, dir, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver with E0/F0 prefix tracking and arrow-key direction decode
// Define PS2_PARITY_CHECK_EN to reject frames with bad (even) parity.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic       clk,
  input logic       rst,
  ps2_key_if.master bus
);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        st;
  logic [1:0]    c_s, d_s;
  logic          c_q;
  logic [2:0]    bcnt;
  logic [7:0]    sr;
  logic          par_ok, ext_p, brk_p;
  logic [TW-1:0] tmo;
  logic          fall, d, arrow;
  logic [1:0]    dir_n;
  assign fall = c_q & ~c_s[1];
  assign d    = d_s[1];
  always_comb begin
    arrow = ext_p & ~brk_p & (sr == 8'h75 || sr == 8'h72 || sr == 8'h6B || sr == 8'h74);
    dir_n = sr == 8'h75 ? 2'd0 : sr == 8'h72 ? 2'd1 : sr == 8'h6B ? 2'd2 : 2'd3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_s           <= 2'b11;
      d_s           <= 2'b11;
      c_q           <= 1'b1;
      st            <= IDLE;
      bcnt          <= '0;
      sr            <= '0;
      par_ok        <= 1'b0;
      ext_p         <= 1'b0;
      brk_p         <= 1'b0;
      tmo           <= '0;
      bus.key_valid <= 1'b0;
      bus.key_code  <= '0;
      bus.key_ext   <= 1'b0;
      bus.key_break <= 1'b0;
      bus.dir_valid <= 1'b0;
      bus.dir       <= 2'd3;
      bus.frame_err <= 1'b0;
    end else begin
      c_s           <= {c_s[0], bus.PS2Clk};
      d_s           <= {d_s[0], bus.PS2Data};
      c_q           <= c_s[1];
      bus.key_valid <= 1'b0;
      bus.dir_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      if (fall) begin
        tmo <= '0;
        case (st)
          IDLE: if (!d) begin
            st   <= DATA;
            bcnt <= '0;
          end
          DATA: begin
            sr   <= {d, sr[7:1]};
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) st <= PARITY;
          end
          PARITY: begin
            par_ok <= (^{sr, d}) | ~PAR_EN;
            st     <= STOP;
          end
          STOP: begin
            st <= IDLE;
            if (d && par_ok) begin
              if (sr == 8'hE0) ext_p <= 1'b1;
              else if (sr == 8'hF0) brk_p <= 1'b1;
              else begin
                bus.key_valid <= 1'b1;
                bus.key_code  <= sr;
                bus.key_ext   <= ext_p;
                bus.key_break <= brk_p;
                ext_p         <= 1'b0;
                brk_p         <= 1'b0;
                if (arrow) begin
                  bus.dir_valid <= 1'b1;
                  bus.dir       <= dir_n;
                end
              end
            end else bus.frame_err <= 1'b1;
          end
          default: st <= IDLE;
        endcase
      end else if (st != IDLE) begin
        // A stalled keyboard clock abandons the frame and any half-built prefix
        if (tmo == TMO_LAST) begin
          st            <= IDLE;
          ext_p         <= 1'b0;
          brk_p         <= 1'b0;
          tmo           <= '0;
          bus.frame_err <= 1'b1;
        end else tmo <= tmo + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frame stimulus with immediate-assertion checks
module tb_ps2_key_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  int kv_cnt = 0, dv_cnt = 0, fe_cnt = 0;
  int k0, d0, f0, n;
  ps2_key_if bus();
  ps2_key_decoder #(.TIMEOUT_CYCLES(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.key_valid) kv_cnt++;
    if (bus.dir_valid) dv_cnt++;
    if (bus.frame_err) fe_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    bus.PS2Data = b;
    repeat (10) @(posedge clk);
    bus.PS2Clk = 1'b0;
    repeat (10) @(posedge clk);
    bus.PS2Clk = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ flip);
    send_bit(stop);
    bus.PS2Data = 1'b1;
    repeat (20) @(posedge clk);
  endtask
  task automatic snap;
    k0 = kv_cnt;
    d0 = dv_cnt;
    f0 = fe_cnt;
  endtask
  initial begin
    bus.PS2Clk  = 1'b1;
    bus.PS2Data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_key_code", bus.key_code, 8'h00);
    chk("rst_key_ext", bus.key_ext, 0);
    chk("rst_key_break", bus.key_break, 0);
    chk("rst_dir_valid", bus.dir_valid, 0);
    chk("rst_dir", bus.dir, 2'd3);
    chk("rst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    snap();
    send_byte(8'hE0, 0, 1);
    chk("e0_no_key", kv_cnt, k0);
    send_byte(8'h75, 0, 1);
    chk("up_kv", kv_cnt, k0 + 1);
    chk("up_code", bus.key_code, 8'h75);
    chk("up_ext", bus.key_ext, 1);
    chk("up_brk", bus.key_break, 0);
    chk("up_dv", dv_cnt, d0 + 1);
    chk("up_dir", bus.dir, 2'd0);
    chk("up_fe", fe_cnt, f0);
    snap();
    send_byte(8'hE0, 0, 1);
    send_byte(8'hF0, 0, 1);
    send_byte(8'h6B, 0, 1);
    chk("lbrk_kv", kv_cnt, k0 + 1);
    chk("lbrk_code", bus.key_code, 8'h6B);
    chk("lbrk_ext", bus.key_ext, 1);
    chk("lbrk_brk", bus.key_break, 1);
    chk("lbrk_dv", dv_cnt, d0);
    chk("lbrk_dir", bus.dir, 2'd0);
    snap();
    send_byte(8'h1C, 1, 1);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_fe", fe_cnt, f0 + 1);
    chk("par_kv", kv_cnt, k0);
`else
    chk("par_fe", fe_cnt, f0);
    chk("par_kv", kv_cnt, k0 + 1);
    chk("par_code", bus.key_code, 8'h1C);
    chk("par_ext", bus.key_ext, 0);
    chk("par_brk", bus.key_break, 0);
`endif
    snap();
    send_byte(8'hE0, 0, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.PS2Data = 1'b1;
    n = 10;
    while (fe_cnt == f0 && n < 1500) begin
      @(posedge clk);
      n++;
    end
    chk("tmo_fe", fe_cnt, f0 + 1);
    chk("tmo_window", (n >= 998 && n <= 1010) ? 1 : 0, 1);
    chk("tmo_kv", kv_cnt, k0);
    repeat (20) @(posedge clk);
    snap();
    send_byte(8'h74, 0, 1);
    chk("tmo_clr_kv", kv_cnt, k0 + 1);
    chk("tmo_clr_ext", bus.key_ext, 0);
    chk("tmo_clr_dv", dv_cnt, d0);
    snap();
    send_byte(8'hE0, 0, 1);
    send_byte(8'h74, 0, 1);
    chk("right_dv", dv_cnt, d0 + 1);
    chk("right_dir", bus.dir, 2'd3);
    chk("right_code", bus.key_code, 8'h74);
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_dir", bus.dir, 2'd3);
    chk("midrst_code", bus.key_code, 8'h00);
    rst = 1'b0;
    bus.PS2Data = 1'b1;
    repeat (10) @(posedge clk);
    send_byte(8'h72, 0, 1);
    chk("midrst_kv", kv_cnt, k0 + 1);
    chk("midrst_code72", bus.key_code, 8'h72);
    chk("midrst_ext", bus.key_ext, 0);
    chk("midrst_fe", fe_cnt, f0);
    chk("midrst_dv", dv_cnt, d0);
    snap();
    send_byte(8'hE0, 0, 1);
    send_byte(8'h29, 0, 0);
    chk("stop_fe", fe_cnt, f0 + 1);
    chk("stop_kv", kv_cnt, k0);
    send_byte(8'h75, 0, 1);
    chk("stop_next_kv", kv_cnt, k0 + 1);
    chk("stop_next_ext", bus.key_ext, 1);
    chk("stop_next_dv", dv_cnt, d0 + 1);
    chk("stop_next_dir", bus.dir, 2'd0);
    snap();
    send_byte(8'h6B, 0, 1);
    chk("kp_kv", kv_cnt, k0 + 1);
    chk("kp_ext", bus.key_ext, 0);
    chk("kp_dv", dv_cnt, d0);
    chk("kp_dir", bus.dir, 2'd0);
    chk("kp_fe", fe_cnt, f0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
